mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access pipeline stage between EX and WB. Accepts one instruction per handshake from EX.
//  Waits for the data-SRAM response of any load/store that EX already issued, then aligns and
//  extends load data. Forwards the packed result to WB, drops in-flight work on flush, and drains
//  responses orphaned by a flush.
// PARAMETERS
//  EX_BUS_W  77  EX->ME bus width: {syscall,ertn,pc[31:0],gr_we,dest[4:0],mem_req,mem_op[2:0],res_from_mem,alu_res[31:0]}
//  WB_BUS_W  72  ME->WB bus width: {syscall[71],ertn[70],pc[69:38],gr_we[37],dest[36:32],result[31:0]}
// PORTS
//  clk               in   1         clock
//  reset             in   1         synchronous, active-high
//  EX_to_ME_Valid    in   1         EX holds a valid instruction
//  EX_to_ME_Bus      in   EX_BUS_W  EX payload
//  ME_Allow_in       out  1         stage can accept from EX this cycle
//  WB_Allow_in       in   1         WB can accept this cycle
//  ME_to_WB_Valid    out  1         valid instruction offered to WB
//  ME_to_WB_Bus      out  WB_BUS_W  WB payload
//  data_sram_data_ok in   1         one-cycle pulse: response for oldest outstanding request
//  data_sram_rdata   in   32        load data, valid with data_ok
//  flush             in   1         ertn_flush | excp_flush from WB
//  ME_dest           out  5         dest & {5{gr_we & ME_Valid}}, for hazard detection
//  ME_Forward_Res    out  32        current result (aligned load data once returned)
//  ME_to_ID_Sys_op   out  1         (syscall|ertn) & ME_Valid
// BEHAVIOUR
//  Reset: ME_Valid=0, state=IDLE, all regs 0. ME_to_WB_Valid=0, ME_dest=0, ME_to_ID_Sys_op=0, ME_Allow_in=1.
//  Handshake: ME_ReadyGo = !mem_req | data_got.
//   ME_Allow_in = (!ME_Valid | (ME_ReadyGo & WB_Allow_in)) & state!=CANCEL.
//   ME_to_WB_Valid = ME_Valid & ME_ReadyGo & !flush.
//  Latch: on EX_to_ME_Valid & ME_Allow_in, capture bus fields and set ME_Valid=1, state=IDLE.
//   On ME_Allow_in without EX valid, set ME_Valid=0.
//  FSM, 2-bit: IDLE, WAIT, DONE, CANCEL.
//   IDLE: a latched insn with mem_req=1 -> WAIT next cycle. mem_req=0 -> result=alu_res, ReadyGo=1.
//   WAIT: data_ok -> capture aligned data into rdata_q, data_got=1, go to DONE.
//   DONE: hold rdata_q until WB accepts, then IDLE. If a new insn enters the same cycle, follow its IDLE rule.
//   CANCEL: flush arrived in WAIT. Next data_ok is discarded -> IDLE. ME_Allow_in=0 while in CANCEL.
//   In WAIT, data_ok and flush in the same cycle: the response is consumed and discarded -> IDLE (no CANCEL).
//  Flush (any state but CANCEL): ME_Valid<=0 next cycle and ME_to_WB_Valid forced 0 in the flush cycle.
//   State goes WAIT->CANCEL; otherwise -> IDLE.
//  Latency: non-mem op 1 cycle through the stage. Load/store: the data_ok cycle is bypassed combinationally,
//   so ReadyGo=1 in that cycle. data_got = (state==WAIT & data_ok) | state==DONE.
//  Load align, addr = alu_res[1:0]:
//   mem_op 000 ld.b  sign-extend byte[addr]
//   mem_op 100 ld.bu zero-extend byte[addr]
//   mem_op 001 ld.h  sign-extend half[addr[1]]
//   mem_op 101 ld.hu zero-extend half[addr[1]]
//   mem_op 010 ld.w  word (addr ignored)
//   Other encodings are treated as ld.w.
//  result = res_from_mem ? aligned_load : alu_res. Stores (mem_req=1, res_from_mem=0) wait for data_ok, pass alu_res.
//  At most one outstanding request. data_ok in IDLE/DONE is a protocol error: ignore it, state unchanged.
//  Reset mid-WAIT returns to IDLE immediately. The external memory is reset on the same reset.
// TESTING
//  ALU op, mem_req=0, alu_res=0x1234 -> ME_to_WB_Valid next cycle, result=0x1234, ME_Allow_in stays 1.
//  ld.b at addr 0x...3, data_ok after 3 cycles, rdata=0x80FF_0000 -> result=0xFFFFFF80.
//   ME_to_WB_Valid asserted in the data_ok cycle only.
//  ld.hu at addr 0x...2, rdata=0xBEEF_1234 -> result=0x0000BEEF. Same with WB_Allow_in=0 for 2 cycles
//   -> result held stable (DONE).
//  Load in WAIT, flush pulse, then data_ok 2 cycles later -> ME_Allow_in=0 until that data_ok.
//   No ME_to_WB_Valid for either. A new insn accepted the cycle after.
//  WAIT with data_ok and flush in the same cycle -> no WB valid, state IDLE next cycle, ME_Allow_in=1.
//  syscall insn in stage -> ME_to_ID_Sys_op=1. ME_dest=dest only when gr_we=1. Reset asserted mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Purpose: handshake and data-SRAM response signals of the memory-access stage.
// Ports (signals):
//   EX_to_ME_Valid / EX_to_ME_Bus : instruction offered by EX
//   ME_Allow_in                   : stage can accept from EX this cycle
//   WB_Allow_in                   : WB can accept this cycle
//   ME_to_WB_Valid / ME_to_WB_Bus : result offered to WB
//   data_sram_data_ok / rdata     : response for the oldest outstanding request
// Modports: master = the stage itself, slave = its environment (EX, WB, SRAM).
interface mem_access_stage_if #(
    parameter int unsigned EX_BUS_W = 77,
    parameter int unsigned WB_BUS_W = 72
);
    logic                EX_to_ME_Valid;
    logic [EX_BUS_W-1:0] EX_to_ME_Bus;
    logic                ME_Allow_in;
    logic                WB_Allow_in;
    logic                ME_to_WB_Valid;
    logic [WB_BUS_W-1:0] ME_to_WB_Bus;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;

    modport master (
        input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_data_ok, data_sram_rdata,
        output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
    );

    modport slave (
        output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_data_ok, data_sram_rdata,
        input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus
    );
endinterface

// File: rtl/mem_access_stage.sv
// Purpose: memory-access pipeline stage between EX and WB. Holds one instruction,
//   waits for the data-SRAM response of a load/store issued by EX, aligns and
//   extends load data, forwards the packed result to WB, drops work on flush and
//   drains a response orphaned by a flush.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (master)      : EX/WB handshake and data-SRAM response (mem_access_stage_if)
//   flush             : ertn/exception flush from WB
//   ME_dest           : destination register for hazard detection (0 when not writing)
//   ME_Forward_Res    : current result, aligned load data once returned
//   ME_to_ID_Sys_op   : syscall/ertn instruction present in the stage
module mem_access_stage #(
    parameter int unsigned EX_BUS_W = 77,
    parameter int unsigned WB_BUS_W = 72
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_stage_if.master  bus,
    input  logic                flush,
    output logic [4:0]          ME_dest,
    output logic [31:0]         ME_Forward_Res,
    output logic                ME_to_ID_Sys_op
);

    typedef struct packed {
        logic        syscall;
        logic        ertn;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic [2:0]  mem_op;
        logic        res_from_mem;
        logic [31:0] alu_res;
    } ex_bus_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        DONE   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    // Bus widths are fixed by the field layout; catch a mismatched override.
    if (EX_BUS_W != $bits(ex_bus_t)) begin : g_bad_ex_w
        $error("EX_BUS_W must equal the EX->ME field layout width");
    end
    if (WB_BUS_W != 72) begin : g_bad_wb_w
        $error("WB_BUS_W must equal the ME->WB field layout width");
    end

    state_t      state;
    logic        me_valid;
    ex_bus_t     ex_q;
    logic [31:0] rdata_q;

    ex_bus_t     ex_in;
    logic        data_got;
    logic        ready_go;
    logic        allow_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_aligned;
    logic [31:0] mem_data;
    logic [31:0] result;

    assign ex_in = bus.EX_to_ME_Bus;

    // The data_ok cycle is bypassed so the instruction can leave in that same cycle.
    assign data_got = (state == WAIT && bus.data_sram_data_ok) || state == DONE;
    assign ready_go = !ex_q.mem_req || data_got;
    assign allow_in = (!me_valid || (ready_go && bus.WB_Allow_in)) && state != CANCEL;

    // Load data alignment and extension from the live SRAM read data.
    always_comb begin
        byte_sel     = 8'h00;
        half_sel     = 16'h0000;
        load_aligned = bus.data_sram_rdata;
        case (ex_q.alu_res[1:0])
            2'd0:    byte_sel = bus.data_sram_rdata[7:0];
            2'd1:    byte_sel = bus.data_sram_rdata[15:8];
            2'd2:    byte_sel = bus.data_sram_rdata[23:16];
            default: byte_sel = bus.data_sram_rdata[31:24];
        endcase
        half_sel = ex_q.alu_res[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
        case (ex_q.mem_op)
            3'b000:  load_aligned = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_aligned = {24'h000000, byte_sel};
            3'b001:  load_aligned = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_aligned = {16'h0000, half_sel};
            default: load_aligned = bus.data_sram_rdata;
        endcase
    end

    // Once the response has been captured, the held copy replaces the live bus.
    assign mem_data = (state == DONE) ? rdata_q : load_aligned;
    assign result   = ex_q.res_from_mem ? mem_data : ex_q.alu_res;

    // Stage register and response-tracking FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            me_valid <= 1'b0;
            ex_q     <= '0;
            rdata_q  <= 32'h0;
        end else if (state == CANCEL) begin
            // Swallow the response belonging to the flushed request.
            if (bus.data_sram_data_ok) begin
                state <= IDLE;
            end
        end else if (flush) begin
            me_valid <= 1'b0;
            // A response still owed to a flushed load/store must be drained.
            state    <= (state == WAIT && !bus.data_sram_data_ok) ? CANCEL : IDLE;
        end else if (allow_in) begin
            me_valid <= bus.EX_to_ME_Valid;
            state    <= IDLE;
            if (bus.EX_to_ME_Valid) begin
                ex_q <= ex_in;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (me_valid && ex_q.mem_req) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.data_sram_data_ok) begin
                        state   <= DONE;
                        rdata_q <= load_aligned;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ME_Allow_in    = allow_in;
    assign bus.ME_to_WB_Valid = me_valid && ready_go && !flush;
    assign bus.ME_to_WB_Bus   = {ex_q.syscall, ex_q.ertn, ex_q.pc, ex_q.gr_we, ex_q.dest, result};
    assign ME_dest            = ex_q.dest & {5{ex_q.gr_we && me_valid}};
    assign ME_Forward_Res     = result;
    assign ME_to_ID_Sys_op    = (ex_q.syscall || ex_q.ertn) && me_valid;

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: self-checking bench for mem_access_stage. A transaction-level model
//   (current instruction, response-received flag, orphan-pending flag, and a
//   memory that answers each request after a chosen delay) predicts every output
//   each cycle; directed sequences additionally pin literal values.
module tb_mem_access_stage;

    typedef struct packed {
        logic        sys;
        logic        ertn;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic [2:0]  op;
        logic        rfm;
        logic [31:0] alu;
    } insn_t;

    logic clk;
    logic reset;
    logic flush;
    logic [4:0]  me_dest;
    logic [31:0] me_fwd;
    logic        me_sys;

    mem_access_stage_if #(.EX_BUS_W(77), .WB_BUS_W(72)) ifc ();

    mem_access_stage #(.EX_BUS_W(77), .WB_BUS_W(72)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (ifc),
        .flush           (flush),
        .ME_dest         (me_dest),
        .ME_Forward_Res  (me_fwd),
        .ME_to_ID_Sys_op (me_sys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Drive requests for the next cycle.
    logic  d_ex_valid;
    insn_t d_insn;
    logic  d_wb_allow;
    logic  d_flush;
    int    d_delay;
    logic  use_force_rd;
    logic [31:0] force_rd;

    // Model state.
    logic        m_valid;
    insn_t       m_cur;
    logic        m_got;
    logic [31:0] m_data;
    logic        m_cancel;
    int          m_age;
    logic        mem_pending;
    int          mem_wait;
    logic        last_taken;

    // Last sampled DUT outputs.
    logic        s_wb_valid;
    logic        s_allow;
    logic [31:0] s_res;
    logic [4:0]  s_dest;
    logic        s_sys;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [76:0] pack(input insn_t t);
        return {t.sys, t.ertn, t.pc, t.gr_we, t.dest, t.mem_req, t.op, t.rfm, t.alu};
    endfunction

    function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic insn_t rand_insn();
        insn_t t;
        t.sys     = ($urandom_range(0, 15) == 0);
        t.ertn    = ($urandom_range(0, 15) == 0);
        t.pc      = $urandom();
        t.gr_we   = 1'($urandom_range(0, 1));
        t.dest    = 5'($urandom());
        t.mem_req = 1'($urandom_range(0, 1));
        t.op      = 3'($urandom());
        t.rfm     = t.mem_req && ($urandom_range(0, 3) != 0);
        t.alu     = $urandom();
        return t;
    endfunction

    // One clock cycle: apply inputs, check all outputs against the model, advance the model.
    task automatic cycle();
        logic        dok;
        logic [31:0] rd;
        logic        got_now;
        logic        ready;
        logic        exp_v;
        logic        exp_allow;
        logic [31:0] src;
        logic [31:0] exp_res;
        @(negedge clk);
        dok = mem_pending && (mem_wait == 0);
        rd  = (dok && use_force_rd) ? force_rd : 32'($urandom());
        ifc.data_sram_data_ok = dok;
        ifc.data_sram_rdata   = rd;
        ifc.EX_to_ME_Valid    = d_ex_valid;
        ifc.EX_to_ME_Bus      = pack(d_insn);
        ifc.WB_Allow_in       = d_wb_allow;
        flush                 = d_flush;
        #1;
        got_now   = m_got || (m_valid && !m_cancel && dok);
        ready     = !m_cur.mem_req || got_now;
        exp_v     = m_valid && ready && !d_flush;
        exp_allow = !m_cancel && (!m_valid || (ready && d_wb_allow));
        src       = m_got ? m_data : rd;
        exp_res   = m_cur.rfm ? ref_align(m_cur.op, m_cur.alu[1:0], src) : m_cur.alu;

        s_wb_valid = ifc.ME_to_WB_Valid;
        s_allow    = ifc.ME_Allow_in;
        s_res      = me_fwd;
        s_dest     = me_dest;
        s_sys      = me_sys;

        chk("wb_valid", 72'(s_wb_valid), 72'(exp_v));
        chk("allow_in", 72'(s_allow), 72'(exp_allow));
        chk("me_dest", 72'(s_dest), 72'((m_valid && m_cur.gr_we) ? m_cur.dest : 5'd0));
        chk("sys_op", 72'(s_sys), 72'(m_valid && (m_cur.sys || m_cur.ertn)));
        if (exp_v) begin
            chk("wb_bus", ifc.ME_to_WB_Bus,
                {m_cur.sys, m_cur.ertn, m_cur.pc, m_cur.gr_we, m_cur.dest, exp_res});
        end
        if (m_valid && ready) begin
            chk("fwd_res", 72'(s_res), 72'(exp_res));
        end

        last_taken = 1'b0;
        if (mem_pending && mem_wait > 0) mem_wait--;
        if (m_cancel) begin
            if (dok) begin
                m_cancel    = 1'b0;
                mem_pending = 1'b0;
            end
        end else if (d_flush) begin
            if (m_valid && m_cur.mem_req && !got_now) m_cancel = 1'b1;
            if (dok) mem_pending = 1'b0;
            m_valid = 1'b0;
            m_got   = 1'b0;
        end else begin
            if (dok) mem_pending = 1'b0;
            if (exp_allow) begin
                if (d_ex_valid) begin
                    last_taken = 1'b1;
                    m_cur   = d_insn;
                    m_valid = 1'b1;
                    m_age   = 0;
                    m_got   = 1'b0;
                    if (d_insn.mem_req) begin
                        mem_pending = 1'b1;
                        mem_wait    = (d_delay >= 0) ? d_delay : int'($urandom_range(1, 4));
                    end
                end else begin
                    m_valid = 1'b0;
                    m_got   = 1'b0;
                end
            end else begin
                m_age++;
                if (dok && m_valid) begin
                    m_got  = 1'b1;
                    m_data = rd;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        d_ex_valid = 1'b0;
        d_wb_allow = 1'b1;
        d_flush    = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic model_clear();
        m_valid     = 1'b0;
        m_cur       = '0;
        m_got       = 1'b0;
        m_data      = 32'h0;
        m_cancel    = 1'b0;
        m_age       = 0;
        mem_pending = 1'b0;
        mem_wait    = 0;
    endtask

    function automatic insn_t load(input logic [2:0] op, input logic [31:0] addr);
        insn_t t;
        t         = '0;
        t.mem_req = 1'b1;
        t.rfm     = 1'b1;
        t.op      = op;
        t.alu     = addr;
        t.gr_we   = 1'b1;
        t.dest    = 5'd3;
        t.pc      = 32'h1C00_0100;
        return t;
    endfunction

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ifc.EX_to_ME_Valid    = 1'b0;
        ifc.EX_to_ME_Bus      = '0;
        ifc.WB_Allow_in       = 1'b1;
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = 32'h0;
        d_ex_valid   = 1'b0;
        d_insn       = '0;
        d_wb_allow   = 1'b1;
        d_flush      = 1'b0;
        d_delay      = -1;
        use_force_rd = 1'b0;
        force_rd     = 32'h0;
        last_taken   = 1'b0;
        model_clear();

        // Model anchors.
        chk("pin_ldb", 72'(ref_align(3'b000, 2'd3, 32'h80FF_0000)), 72'(32'hFFFF_FF80));
        chk("pin_ldhu", 72'(ref_align(3'b101, 2'd2, 32'hBEEF_1234)), 72'(32'h0000_BEEF));

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wb_valid", 72'(ifc.ME_to_WB_Valid), 72'(0));
        chk("rst_allow", 72'(ifc.ME_Allow_in), 72'(1));
        chk("rst_dest", 72'(me_dest), 72'(0));
        chk("rst_sys", 72'(me_sys), 72'(0));
        reset = 1'b0;

        // ALU op passes in one cycle.
        d_insn = '0; d_insn.alu = 32'h1234; d_insn.gr_we = 1'b1; d_insn.dest = 5'd7;
        d_ex_valid = 1'b1; d_wb_allow = 1'b1; d_flush = 1'b0;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        chk("alu_wb_valid", 72'(s_wb_valid), 72'(1));
        chk("alu_result", 72'(s_res), 72'(32'h1234));
        chk("alu_allow", 72'(s_allow), 72'(1));
        chk("alu_dest", 72'(s_dest), 72'(7));
        idle(1);

        // ld.b at byte 3, response three cycles after entry.
        use_force_rd = 1'b1; force_rd = 32'h80FF_0000; d_delay = 3;
        d_insn = load(3'b000, 32'h0000_1003); d_ex_valid = 1'b1;
        cycle();
        d_ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ldb_wait_valid", 72'(s_wb_valid), 72'(0));
        end
        cycle();
        chk("ldb_ok_valid", 72'(s_wb_valid), 72'(1));
        chk("ldb_result", 72'(s_res), 72'(32'hFFFF_FF80));
        cycle();
        chk("ldb_after_valid", 72'(s_wb_valid), 72'(0));
        idle(1);

        // ld.hu at half 1, WB stalls for two cycles: result held.
        force_rd = 32'hBEEF_1234; d_delay = 1;
        d_insn = load(3'b101, 32'h0000_2002); d_ex_valid = 1'b1; d_wb_allow = 1'b1;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        d_wb_allow = 1'b0;
        cycle();
        chk("ldhu_ok_valid", 72'(s_wb_valid), 72'(1));
        chk("ldhu_result", 72'(s_res), 72'(32'h0000_BEEF));
        chk("ldhu_stall_allow", 72'(s_allow), 72'(0));
        cycle();
        chk("ldhu_held", 72'(s_res), 72'(32'h0000_BEEF));
        d_wb_allow = 1'b1;
        cycle();
        chk("ldhu_release_valid", 72'(s_wb_valid), 72'(1));
        chk("ldhu_release_res", 72'(s_res), 72'(32'h0000_BEEF));
        chk("ldhu_release_allow", 72'(s_allow), 72'(1));
        idle(1);

        // Flush while waiting: the orphan response is drained before new work enters.
        d_delay = 3;
        d_insn = load(3'b010, 32'h0000_3000); d_ex_valid = 1'b1;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        d_flush = 1'b1;
        cycle();
        chk("fl_flush_valid", 72'(s_wb_valid), 72'(0));
        d_flush = 1'b0;
        cycle();
        chk("fl_cancel_allow", 72'(s_allow), 72'(0));
        cycle();
        chk("fl_drain_allow", 72'(s_allow), 72'(0));
        chk("fl_drain_valid", 72'(s_wb_valid), 72'(0));
        d_insn = '0; d_insn.alu = 32'hCAFE_0001; d_ex_valid = 1'b1;
        cycle();
        chk("fl_next_allow", 72'(s_allow), 72'(1));
        d_ex_valid = 1'b0;
        cycle();
        chk("fl_next_valid", 72'(s_wb_valid), 72'(1));
        chk("fl_next_res", 72'(s_res), 72'(32'hCAFE_0001));
        idle(1);

        // data_ok coincident with flush: consumed, no drain state.
        d_delay = 1;
        d_insn = load(3'b010, 32'h0000_4000); d_ex_valid = 1'b1;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        d_flush = 1'b1;
        cycle();
        chk("okfl_valid", 72'(s_wb_valid), 72'(0));
        d_flush = 1'b0;
        cycle();
        chk("okfl_allow", 72'(s_allow), 72'(1));
        chk("okfl_after_valid", 72'(s_wb_valid), 72'(0));

        // syscall without register write.
        d_insn = '0; d_insn.sys = 1'b1; d_insn.dest = 5'd9; d_ex_valid = 1'b1; d_wb_allow = 1'b0;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        chk("sys_op", 72'(s_sys), 72'(1));
        chk("sys_dest_gated", 72'(s_dest), 72'(0));
        idle(1);

        // Reset while waiting on a response.
        d_delay = 4;
        d_insn = load(3'b000, 32'h0000_5001); d_insn.sys = 1'b1; d_ex_valid = 1'b1;
        cycle();
        d_ex_valid = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        reset = 1'b1;
        ifc.data_sram_data_ok = 1'b0;
        ifc.EX_to_ME_Valid    = 1'b0;
        flush                 = 1'b0;
        @(negedge clk);
        #1;
        chk("rstw_wb_valid", 72'(ifc.ME_to_WB_Valid), 72'(0));
        chk("rstw_dest", 72'(me_dest), 72'(0));
        chk("rstw_sys", 72'(me_sys), 72'(0));
        chk("rstw_fwd", 72'(me_fwd), 72'(0));
        chk("rstw_bus", ifc.ME_to_WB_Bus, 72'(0));
        chk("rstw_allow", 72'(ifc.ME_Allow_in), 72'(1));
        reset = 1'b0;
        model_clear();
        use_force_rd = 1'b0;
        d_delay      = -1;
        idle(1);

        // Randomized traffic.
        d_ex_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!d_ex_valid || last_taken) begin
                d_ex_valid = ($urandom_range(0, 99) < 60);
                d_insn     = rand_insn();
            end
            d_wb_allow = ($urandom_range(0, 99) < 75);
            d_flush    = ($urandom_range(0, 99) < 5) &&
                         !(m_valid && m_cur.mem_req && m_age == 0 && !m_cancel);
            if (d_flush) d_ex_valid = 1'b0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
